i2s_apb_regbank: RTL and testbench
==================================

Name: i2s_apb_regbank

Overview:
- Parametrised APB slave register bank for the I2S transceiver. Replaces the single-word TX/RX holding registers with DEPTH-entry holding buffers.
- Adds proper APB wait and error signalling, sticky overflow/underflow flags, an interrupt enable/status pair, and a flush control.
- Sits between the APB bus and the TX/RX FIFOs. Owns all FIFO push/pop handshakes.

Parameters:
- DW, 32, audio data word width (≤32); TXDATA/RXDATA use bits DW-1:0, upper read bits are 0.
- CTRL_W, 13, width of the CTRL register and of `controls`.
- TXB_DEPTH, 2, TX holding buffer entries (≥1).
- RXB_DEPTH, 2, RX holding buffer entries (≥1).
- ADDR_W, 8, APB address width.

Ports:
- pclk  in  1  APB clock
- preset  in  1  reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1=write
- paddr  in  ADDR_W  byte address
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid with pready
- flags  in  4  transceiver status flags
- controls  out  CTRL_W  CTRL register contents
- tx_full  in  1  TX FIFO full
- tx_wen  out  1  TX FIFO push strobe
- tx_data  out  DW  TX FIFO write data
- rx_empty  in  1  RX FIFO empty
- rx_ren  out  1  RX FIFO pop strobe
- rx_data  in  DW  RX FIFO read data, valid one cycle after rx_ren
- irq  out  1  interrupt, level, active-high

Behaviour:
- Reset: preset, asynchronous, active-low; clock pclk. While preset is low, every register clears: CTRL, IRQ_EN, sticky bits, buffer counts and pointers, FSMs to IDLE; prdata, pready, pslverr, tx_wen, rx_ren and irq are all 0. Reset mid-operation drops buffer contents and any in-flight RX capture.
- Address map (word-aligned; paddr[1:0] ignored):
  - 0x00 CTRL: RW, bits CTRL_W-1:0. Writing pwdata[31]=1 flushes both buffers; bit 31 is not stored.
  - 0x04 STATUS: RO, {flags[3:0], 12'b0, rx_cnt[7:0], tx_cnt[7:0]}.
  - 0x08 TXDATA: WO, push into the TX buffer.
  - 0x0C RXDATA: RO, pop from the RX buffer.
  - 0x10 IRQ_EN: RW, bits 3:0.
  - 0x14 IRQ_STAT: bit0 TX_OVF (sticky, W1C), bit1 RX_UNF (sticky, W1C), bit2 RX_NEMPTY (level, RO), bit3 TX_EMPTY (level, RO).
  - Any other address: reads 0, writes ignored, pslverr=1.
- APB timing:
  - Writes complete with zero wait: pready=1 in the first access cycle (psel&penable).
  - Reads insert one wait state. First access cycle: pready=0 and prdata is registered. Second cycle: pready=1 with data valid.
  - pslverr is 0 whenever pready is 0. Outside the completing cycle, prdata=0 and pready=0.
- TX path:
  - A TXDATA write with tx_cnt<TXB_DEPTH enqueues pwdata[DW-1:0].
  - A TXDATA write with tx_cnt==TXB_DEPTH gives pslverr=1, drops the data and sets TX_OVF. Fullness is judged on the registered count; a same-cycle drain does not make room.
- TX drain FSM, states T_IDLE, T_PUSH, T_GAP:
  - T_IDLE→T_PUSH when tx_cnt>0 and !tx_full.
  - In T_PUSH: tx_wen=1 for exactly one cycle, tx_data=head, head dequeued. Then →T_GAP.
  - T_GAP lasts one cycle so tx_full can update, then →T_IDLE. Maximum rate is one word per 3 cycles.
  - Enqueue and dequeue in the same cycle leave tx_cnt unchanged.
- RX path:
  - An RXDATA read with rx_cnt>0 returns the head and dequeues it at read completion.
  - An RXDATA read with rx_cnt==0 returns 0, pslverr=1 and sets RX_UNF.
- RX fill FSM, states R_IDLE, R_REQ, R_CAP:
  - R_IDLE→R_REQ when !rx_empty and rx_cnt<RXB_DEPTH.
  - In R_REQ: rx_ren=1 for exactly one cycle, then →R_CAP.
  - In R_CAP: capture rx_data into the tail, then →R_IDLE.
  - A capture and an APB pop in the same cycle leave rx_cnt unchanged.
- Flush: clears both buffers at the end of the write cycle. An in-flight R_CAP word is discarded, and a T_PUSH in the same cycle still completes.
- Buffers are circular with pointers wrapping modulo depth. Counts are 8 bits wide, saturating by construction at depth.
- W1C write: bits written as 1 clear TX_OVF/RX_UNF. A set event in the same cycle wins over the clear.
- irq: registered |(IRQ_STAT[3:0] & IRQ_EN[3:0]), so it lags by one cycle.

Test Plan:
- Reset mid-transfer (tx_cnt=2, R_CAP active) → all outputs 0, STATUS reads 0x0 plus flags, and no tx_wen or rx_ren for 3 cycles with tx_full=0 and rx_empty=1.
- Write TXDATA 0xA5A5_0001, 0x0002, 0x0003 with tx_full=1 → third write pslverr=1, TX_OVF=1. Release tx_full → tx_wen pulses 2 times, 3 cycles apart, with 0xA5A5_0001 then 0x0002.
- rx_empty=0 with FIFO data 0x11, 0x22, 0x33 → exactly 2 rx_ren pulses, then stall. Read RXDATA → 0x11 after one wait state, then a third rx_ren. Subsequent reads → 0x22, 0x33.
- Read RXDATA with empty buffer → prdata=0, pslverr=1, RX_UNF=1. With IRQ_EN=0x2, irq rises 1 cycle later. W1C 0x2 → irq falls.
- CTRL write 0x8000_1FFF with a word in each buffer → controls=0x1FFF, STATUS counts 0, TX_EMPTY=1.
- Access to 0x18 → pslverr=1, no state change. Same-cycle TXDATA write and T_PUSH at tx_cnt=1 → tx_cnt stays 1.

Source files
------------

// File: rtl/i2s_apb_regbank.sv
// APB register bank for the I2S transceiver: CTRL/STATUS/IRQ registers plus
// small TX/RX holding buffers that own the push/pop handshakes to the FIFOs.
module i2s_apb_regbank #(
  parameter int DW        = 32,
  parameter int CTRL_W    = 13,
  parameter int TXB_DEPTH = 2,
  parameter int RXB_DEPTH = 2,
  parameter int ADDR_W    = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [3:0]        flags,
  output logic [CTRL_W-1:0] controls,
  input  logic              tx_full,
  output logic              tx_wen,
  output logic [DW-1:0]     tx_data,
  input  logic              rx_empty,
  output logic              rx_ren,
  input  logic [DW-1:0]     rx_data,
  output logic              irq
);

  localparam int TXP_W = (TXB_DEPTH > 1) ? $clog2(TXB_DEPTH) : 1;
  localparam int RXP_W = (RXB_DEPTH > 1) ? $clog2(RXB_DEPTH) : 1;
  localparam logic [7:0] TX_MAX = 8'(TXB_DEPTH);
  localparam logic [7:0] RX_MAX = 8'(RXB_DEPTH);
  localparam logic [TXP_W-1:0] TX_LAST = TXP_W'(TXB_DEPTH - 1);
  localparam logic [RXP_W-1:0] RX_LAST = RXP_W'(RXB_DEPTH - 1);

  localparam int AW = ADDR_W - 2;
  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_STATUS = AW'(1);
  localparam logic [AW-1:0] A_TXDATA = AW'(2);
  localparam logic [AW-1:0] A_RXDATA = AW'(3);
  localparam logic [AW-1:0] A_IRQ_EN = AW'(4);
  localparam logic [AW-1:0] A_IRQ_ST = AW'(5);

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_PUSH = 2'd1, T_GAP = 2'd2} tx_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_CAP = 2'd2} rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [3:0]        irq_en_q, irq_en_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_unf_q, rx_unf_d;
  logic              irq_q, irq_d;

  logic [DW-1:0]     tx_mem_q [TXB_DEPTH];
  logic [DW-1:0]     tx_mem_d [TXB_DEPTH];
  logic [TXP_W-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]        tx_cnt_q, tx_cnt_d;

  logic [DW-1:0]     rx_mem_q [RXB_DEPTH];
  logic [DW-1:0]     rx_mem_d [RXB_DEPTH];
  logic [RXP_W-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0]        rx_cnt_q, rx_cnt_d;

  logic              rd_phase_q, rd_phase_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_err_q, rd_err_d;
  logic              rd_pop_q, rd_pop_d;
  logic              rd_unf_q, rd_unf_d;

  logic [AW-1:0] word;
  logic sel_ctrl, sel_status, sel_tx, sel_rx, sel_ien, sel_ist, addr_ok;
  logic access, wr_acc, wr_done, rd_first, rd_done;
  logic flush, tx_push_req, tx_ovf_evt, tx_enq, tx_deq;
  logic rx_cap, rx_pop, rx_unf_evt, w1c;
  logic wr_err;
  logic [31:0] rd_mux;
  logic [3:0]  irq_stat;
  logic unused_bits;

  assign unused_bits = ^{paddr[1:0], pwdata};

  // APB: a transfer completes in the cycle where psel&penable&pready are all
  // high; pslverr is only meaningful in that cycle. Writes complete in their
  // first access cycle, reads in their second (rd_phase_q marks the wait).
  assign word       = paddr[ADDR_W-1:2];
  assign sel_ctrl   = (word == A_CTRL);
  assign sel_status = (word == A_STATUS);
  assign sel_tx     = (word == A_TXDATA);
  assign sel_rx     = (word == A_RXDATA);
  assign sel_ien    = (word == A_IRQ_EN);
  assign sel_ist    = (word == A_IRQ_ST);
  assign addr_ok    = sel_ctrl | sel_status | sel_tx | sel_rx | sel_ien | sel_ist;

  assign access   = psel & penable;
  assign wr_acc   = access & pwrite;
  assign wr_done  = wr_acc & preset;
  assign rd_first = access & ~pwrite & ~rd_phase_q;
  assign rd_done  = access & ~pwrite & rd_phase_q;

  assign flush       = wr_acc & sel_ctrl & pwdata[31];
  assign tx_push_req = wr_acc & sel_tx;
  assign tx_ovf_evt  = tx_push_req & (tx_cnt_q == TX_MAX);
  assign tx_enq      = tx_push_req & ~tx_ovf_evt;
  assign tx_deq      = (tx_state_q == T_PUSH);
  assign rx_cap      = (rx_state_q == R_CAP) & ~flush;
  assign rx_pop      = rd_done & rd_pop_q;
  assign rx_unf_evt  = rd_done & rd_unf_q;
  assign w1c         = wr_acc & sel_ist;
  assign wr_err      = ~addr_ok | tx_ovf_evt;

  assign pready   = wr_done | rd_done;
  assign pslverr  = (wr_done & wr_err) | (rd_done & rd_err_q);
  assign prdata   = rd_done ? rd_data_q : 32'd0;
  assign controls = ctrl_q;
  assign irq      = irq_q;
  assign irq_stat = {(tx_cnt_q == 8'd0), (rx_cnt_q != 8'd0), rx_unf_q, tx_ovf_q};

  // TX drain FSM
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) tx_state_q <= T_IDLE;
    else         tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_IDLE:  if ((tx_cnt_q != 8'd0) && !tx_full && !flush) tx_state_d = T_PUSH;
      T_PUSH:  tx_state_d = T_GAP;
      T_GAP:   tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    tx_wen  = (tx_state_q == T_PUSH);
    tx_data = tx_mem_q[tx_rd_q];
  end

  // RX fill FSM
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) rx_state_q <= R_IDLE;
    else         rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_IDLE:  if (!rx_empty && (rx_cnt_q < RX_MAX)) rx_state_d = R_REQ;
      R_REQ:   rx_state_d = R_CAP;
      R_CAP:   rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_ren = (rx_state_q == R_REQ);
  end

  // TX holding buffer; a flush wins over any same-cycle enqueue/dequeue.
  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = 8'd0;
    end else begin
      if (tx_enq) begin
        tx_mem_d[tx_wr_q] = pwdata[DW-1:0];
        tx_wr_d = (tx_wr_q == TX_LAST) ? '0 : tx_wr_q + 1'b1;
      end
      if (tx_deq) tx_rd_d = (tx_rd_q == TX_LAST) ? '0 : tx_rd_q + 1'b1;
      tx_cnt_d = tx_cnt_q + 8'(tx_enq) - 8'(tx_deq);
    end
  end

  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = 8'd0;
    end else begin
      if (rx_cap) begin
        rx_mem_d[rx_wr_q] = rx_data;
        rx_wr_d = (rx_wr_q == RX_LAST) ? '0 : rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_d = (rx_rd_q == RX_LAST) ? '0 : rx_rd_q + 1'b1;
      rx_cnt_d = rx_cnt_q + 8'(rx_cap) - 8'(rx_pop);
    end
  end

  // Read data is captured in the first access cycle and presented in the second.
  always_comb begin
    rd_mux = 32'd0;
    if (sel_ctrl)        rd_mux = 32'(ctrl_q);
    else if (sel_status) rd_mux = {flags, 12'd0, rx_cnt_q, tx_cnt_q};
    else if (sel_rx)     rd_mux = (rx_cnt_q != 8'd0) ? 32'(rx_mem_q[rx_rd_q]) : 32'd0;
    else if (sel_ien)    rd_mux = {28'd0, irq_en_q};
    else if (sel_ist)    rd_mux = {28'd0, irq_stat};
  end

  always_comb begin
    rd_phase_d = rd_first;
    rd_data_d  = rd_first ? rd_mux : 32'd0;
    rd_err_d   = rd_first & (~addr_ok | (sel_rx & (rx_cnt_q == 8'd0)));
    rd_pop_d   = rd_first & sel_rx & (rx_cnt_q != 8'd0);
    rd_unf_d   = rd_first & sel_rx & (rx_cnt_q == 8'd0);
  end

  // Control/status registers; a sticky set event beats a same-cycle W1C.
  always_comb begin
    ctrl_d   = ctrl_q;
    irq_en_d = irq_en_q;
    if (wr_acc && sel_ctrl) ctrl_d   = pwdata[CTRL_W-1:0];
    if (wr_acc && sel_ien)  irq_en_d = pwdata[3:0];
    tx_ovf_d = (tx_ovf_q & ~(w1c & pwdata[0])) | tx_ovf_evt;
    rx_unf_d = (rx_unf_q & ~(w1c & pwdata[1])) | rx_unf_evt;
    irq_d    = |(irq_stat & irq_en_q);
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      ctrl_q     <= '0;
      irq_en_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
      irq_q      <= 1'b0;
      for (int i = 0; i < TXB_DEPTH; i++) tx_mem_q[i] <= '0;
      for (int i = 0; i < RXB_DEPTH; i++) rx_mem_q[i] <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= 8'd0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= 8'd0;
      rd_phase_q <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_err_q   <= 1'b0;
      rd_pop_q   <= 1'b0;
      rd_unf_q   <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      irq_en_q   <= irq_en_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_unf_q   <= rx_unf_d;
      irq_q      <= irq_d;
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      rd_phase_q <= rd_phase_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      rd_pop_q   <= rd_pop_d;
      rd_unf_q   <= rd_unf_d;
    end
  end

endmodule

// File: tb/tb_i2s_apb_regbank.sv
// Directed bench for i2s_apb_regbank: APB driver tasks, a modelled RX FIFO,
// and an expected queue for words leaving on the TX push strobe.
module tb_i2s_apb_regbank;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [3:0]  flags;
  logic [12:0] controls;
  logic        tx_full, tx_wen;
  logic [31:0] tx_data;
  logic        rx_empty, rx_ren;
  logic [31:0] rx_data;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  logic [31:0] exp_q[$];
  int          wen_cyc[$];
  logic [31:0] src [4];
  int src_n = 0;
  int src_idx = 0;

  i2s_apb_regbank dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .flags(flags), .controls(controls), .tx_full(tx_full), .tx_wen(tx_wen),
    .tx_data(tx_data), .rx_empty(rx_empty), .rx_ren(rx_ren), .rx_data(rx_data), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: step past the edge, then monitor TX pushes and answer RX pops.
  task automatic cyc();
    @(posedge pclk);
    #1;
    cyc_n++;
    if (tx_wen) begin
      wen_cnt++;
      wen_cyc.push_back(cyc_n);
      chk("tx_wen_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q.pop_front());
    end
    if (rx_ren) begin
      ren_cnt++;
      if (src_idx < src_n) begin
        rx_data = src[src_idx];
        src_idx++;
      end
      rx_empty = (src_idx >= src_n);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d,
                        input logic exp_err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    cyc();
    penable = 1'b1;
    #1;
    chk({tag, "_pready"}, 32'(pready), 32'd1);
    chk({tag, "_pslverr"}, 32'(pslverr), 32'(exp_err));
    cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                        input logic exp_err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    cyc();
    penable = 1'b1;
    #1;
    chk({tag, "_wait_pready"}, 32'(pready), 32'd0);
    chk({tag, "_wait_prdata"}, prdata, 32'd0);
    cyc();
    #1;
    chk({tag, "_pready"}, 32'(pready), 32'd1);
    chk({tag, "_prdata"}, prdata, exp_d);
    chk({tag, "_pslverr"}, 32'(pslverr), 32'(exp_err));
    cyc();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int w0;
    int r0;
    preset = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 32'h0;
    flags = 4'hA; tx_full = 1'b0; rx_empty = 1'b1; rx_data = 32'h0;
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_controls", 32'(controls), 32'h0);
    cycles(3);
    preset = 1'b1;
    cyc();

    // Register reads straight out of reset
    rd_chk("status0", 8'h04, 32'hA000_0000, 1'b0);
    rd_chk("irqstat0", 8'h14, 32'h0000_0008, 1'b0);

    // TX overflow with the FIFO full, then drain
    tx_full = 1'b1;
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'h0000_0002);
    wr_chk("txw1", 8'h08, 32'hA5A5_0001, 1'b0);
    wr_chk("txw2", 8'h08, 32'h0000_0002, 1'b0);
    wr_chk("txw3_ovf", 8'h08, 32'h0000_0003, 1'b1);
    rd_chk("status_tx2", 8'h04, 32'hA000_0002, 1'b0);
    rd_chk("irqstat_ovf", 8'h14, 32'h0000_0001, 1'b0);
    chk("tx_no_push_full", 32'(wen_cnt), 32'd0);
    tx_full = 1'b0;
    cycles(10);
    chk("tx_pulses", 32'(wen_cnt), 32'd2);
    if (wen_cyc.size() == 2) chk("tx_gap", 32'(wen_cyc[1] - wen_cyc[0]), 32'd3);
    wr_chk("w1c_ovf", 8'h14, 32'h0000_0001, 1'b0);
    rd_chk("irqstat_clr", 8'h14, 32'h0000_0008, 1'b0);

    // RX fill stalls at two entries, refills after each pop
    src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33;
    src_n = 3; src_idx = 0; rx_empty = 1'b0;
    cycles(12);
    chk("rx_ren_stall", 32'(ren_cnt), 32'd2);
    rd_chk("status_rx2", 8'h04, 32'hA000_0200, 1'b0);
    rd_chk("irqstat_nempty", 8'h14, 32'h0000_000C, 1'b0);
    rd_chk("rx_pop1", 8'h0C, 32'h11, 1'b0);
    cycles(6);
    chk("rx_ren_third", 32'(ren_cnt), 32'd3);
    rd_chk("rx_pop2", 8'h0C, 32'h22, 1'b0);
    cycles(2);
    rd_chk("rx_pop3", 8'h0C, 32'h33, 1'b0);
    cycles(4);
    chk("rx_ren_done", 32'(ren_cnt), 32'd3);

    // RX underflow raises RX_UNF; irq follows a cycle later, W1C drops it
    wr_chk("ien_unf", 8'h10, 32'h0000_0002, 1'b0);
    rd_chk("rx_unf", 8'h0C, 32'h0, 1'b1);
    chk("irq_lag", 32'(irq), 32'd0);
    cyc();
    chk("irq_rise", 32'(irq), 32'd1);
    rd_chk("irqstat_unf", 8'h14, 32'h0000_000A, 1'b0);
    wr_chk("w1c_unf", 8'h14, 32'h0000_0002, 1'b0);
    chk("irq_hold", 32'(irq), 32'd1);
    cyc();
    chk("irq_fall", 32'(irq), 32'd0);
    wr_chk("ien_off", 8'h10, 32'h0, 1'b0);

    // Flush with one word in each buffer
    tx_full = 1'b1;
    wr_chk("tx_flushw", 8'h08, 32'h0000_0055, 1'b0);
    src[0] = 32'h44; src_n = 1; src_idx = 0; rx_empty = 1'b0;
    cycles(6);
    rd_chk("status_pre_flush", 8'h04, 32'hA000_0101, 1'b0);
    wr_chk("ctrl_flush", 8'h00, 32'h8000_1FFF, 1'b0);
    chk("controls_1fff", 32'(controls), 32'h0000_1FFF);
    rd_chk("status_flushed", 8'h04, 32'hA000_0000, 1'b0);
    rd_chk("irqstat_flushed", 8'h14, 32'h0000_0008, 1'b0);
    rd_chk("ctrl_rd", 8'h00, 32'h0000_1FFF, 1'b0);
    w0 = wen_cnt;
    tx_full = 1'b0;
    cycles(6);
    chk("tx_none_after_flush", 32'(wen_cnt), 32'(w0));

    // Unmapped address
    wr_chk("bad_wr", 8'h18, 32'hFFFF_FFFF, 1'b1);
    rd_chk("bad_rd", 8'h18, 32'h0, 1'b1);
    chk("controls_kept", 32'(controls), 32'h0000_1FFF);
    rd_chk("status_kept", 8'h04, 32'hA000_0000, 1'b0);

    // TXDATA write landing in the same cycle as T_PUSH at tx_cnt=1
    tx_full = 1'b1;
    exp_q.push_back(32'h0000_00B1);
    exp_q.push_back(32'h0000_00B2);
    wr_chk("tx_b1", 8'h08, 32'h0000_00B1, 1'b0);
    tx_full = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0000_00B2;
    w0 = wen_cnt;
    cyc();
    penable = 1'b1;
    #1;
    chk("same_cyc_push", 32'(wen_cnt), 32'(w0 + 1));
    chk("same_cyc_pready", 32'(pready), 32'd1);
    chk("same_cyc_pslverr", 32'(pslverr), 32'd0);
    cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_full = 1'b1;
    rd_chk("status_tx1", 8'h04, 32'hA000_0001, 1'b0);
    tx_full = 1'b0;
    cycles(8);
    chk("tx_exp_drained", 32'(exp_q.size()), 32'd0);
    rd_chk("status_tx0", 8'h04, 32'hA000_0000, 1'b0);

    // Reset with tx_cnt=2 and an RX capture in flight
    tx_full = 1'b1;
    wr_chk("tx_c1", 8'h08, 32'h0000_00C1, 1'b0);
    wr_chk("tx_c2", 8'h08, 32'h0000_00C2, 1'b0);
    src[0] = 32'h66; src[1] = 32'h77; src_n = 2; src_idx = 0; rx_empty = 1'b0;
    r0 = ren_cnt;
    cycles(2);
    chk("rx_req_before_rst", 32'(ren_cnt), 32'(r0 + 1));
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08;
    preset = 1'b0;
    flags = 4'h5;
    #1;
    chk("mid_rst_pready", 32'(pready), 32'd0);
    chk("mid_rst_pslverr", 32'(pslverr), 32'd0);
    chk("mid_rst_prdata", prdata, 32'h0);
    chk("mid_rst_tx_wen", 32'(tx_wen), 32'd0);
    chk("mid_rst_rx_ren", 32'(rx_ren), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_controls", 32'(controls), 32'h0);
    cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tx_full = 1'b0; rx_empty = 1'b1; src_n = src_idx;
    preset = 1'b1;
    w0 = wen_cnt;
    r0 = ren_cnt;
    cycles(3);
    chk("post_rst_no_wen", 32'(wen_cnt), 32'(w0));
    chk("post_rst_no_ren", 32'(ren_cnt), 32'(r0));
    rd_chk("post_rst_status", 8'h04, 32'h5000_0000, 1'b0);
    rd_chk("post_rst_ien", 8'h10, 32'h0, 1'b0);
    chk("post_rst_controls", 32'(controls), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
